// File: rtl/hwjsoc_sysid_pkg.sv
// ---------------------------------------------------------------------------
// hwjsoc_sysid_pkg
// Shared definitions for the sysid checker:
//   - sysid_state_e   : checker FSM states
//   - SYSID_ADDR_*    : word select values on the sysid slave
//   - SYSID_DEFAULT_* : default expected ID / timestamp / stall limit
//   - sysid_cnt_width : minimum counter width able to hold a given count
// ---------------------------------------------------------------------------
package hwjsoc_sysid_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ID  = 2'd1,
        RD_TS  = 2'd2,
        FINISH = 2'd3
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID      = 32'd16;
    localparam logic [31:0] SYSID_DEFAULT_TS      = 32'd1589565123;
    localparam int unsigned SYSID_DEFAULT_TIMEOUT = 255;

    // Bits needed to represent values 0..max_count inclusive.
    function automatic int unsigned sysid_cnt_width(input int unsigned max_count);
        if (max_count <= 1) begin
            return 1;
        end
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/hwjsoc_timeout_counter.sv
// ---------------------------------------------------------------------------
// hwjsoc_timeout_counter
// Counts stalled cycles of one read and flags when the limit is reached.
// Ports:
//   clock    in  : clock, rising edge
//   reset_n  in  : synchronous active-low reset (count -> 0)
//   clear    in  : restart count at 0 (priority over enable)
//   enable   in  : count this cycle (a stalled read cycle)
//   expired  out : count has reached TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module hwjsoc_timeout_counter
    import hwjsoc_sysid_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = SYSID_DEFAULT_TIMEOUT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned         CNT_W   = sysid_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Expired is taken straight from the register so that the stall which
    // brings the count to the limit is still allowed to complete next cycle.
    assign expired = (count_q == CNT_MAX);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            // Saturates at the limit; the FSM leaves the read state anyway.
            count_d = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hwjsoc_sysid_checker.sv
// ---------------------------------------------------------------------------
// hwjsoc_sysid_checker
// Reads the sysid slave (word 0 = system ID, word 1 = build timestamp) over
// Avalon-MM and compares both against expected values.
// Ports:
//   clock           in      : clock, rising edge
//   reset_n         in      : synchronous active-low reset
//   start           in      : one-cycle request, honoured only when idle
//   avm_address     out     : word select (0 = ID, 1 = timestamp)
//   avm_read        out     : read request
//   avm_readdata    in  32  : read data, valid when read=1 and waitrequest=0
//   avm_waitrequest in      : responder stall
//   busy            out     : sequence in progress
//   done            out     : one-cycle pulse when the sequence ends
//   id_ok           out     : captured ID matched EXPECTED_ID
//   ts_ok           out     : captured timestamp matched EXPECTED_TS
//   timeout         out     : a read stalled past TIMEOUT_CYCLES
//   id_value        out 32  : last captured ID word
//   ts_value        out 32  : last captured timestamp word
// ---------------------------------------------------------------------------
module hwjsoc_sysid_checker
    import hwjsoc_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter int unsigned TIMEOUT_CYCLES = SYSID_DEFAULT_TIMEOUT,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    sysid_state_e state_q, state_d;
    logic         auto_q, auto_d;
    logic         avm_read_q, avm_read_d;
    logic         avm_address_q, avm_address_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         id_ok_q, id_ok_d;
    logic         ts_ok_q, ts_ok_d;
    logic         timeout_q, timeout_d;
    logic [31:0]  id_value_q, id_value_d;
    logic [31:0]  ts_value_q, ts_value_d;

    logic         cnt_clear;
    logic         cnt_enable;
    logic         cnt_expired;

    assign cnt_enable = ((state_q == RD_ID) || (state_q == RD_TS)) && avm_waitrequest;

    hwjsoc_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    always_comb begin
        state_d       = state_q;
        auto_d        = 1'b0;  // auto launch is a single shot after reset
        avm_read_d    = avm_read_q;
        avm_address_d = avm_address_q;
        done_d        = 1'b0;
        id_ok_d       = id_ok_q;
        ts_ok_d       = ts_ok_q;
        timeout_d     = timeout_q;
        id_value_d    = id_value_q;
        ts_value_d    = ts_value_q;
        cnt_clear     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start || auto_q) begin
                    state_d       = RD_ID;
                    avm_read_d    = 1'b1;
                    avm_address_d = SYSID_ADDR_ID;
                    id_ok_d       = 1'b0;
                    ts_ok_d       = 1'b0;
                    timeout_d     = 1'b0;
                    cnt_clear     = 1'b1;
                end
            end
            RD_ID: begin
                // Data acceptance wins over expiry in the same cycle.
                if (!avm_waitrequest) begin
                    id_value_d    = avm_readdata;
                    id_ok_d       = (avm_readdata == EXPECTED_ID);
                    state_d       = RD_TS;
                    avm_address_d = SYSID_ADDR_TS;  // read stays high: back-to-back
                    cnt_clear     = 1'b1;
                end else if (cnt_expired) begin
                    timeout_d  = 1'b1;
                    state_d    = FINISH;
                    avm_read_d = 1'b0;
                    done_d     = 1'b1;
                end
            end
            RD_TS: begin
                if (!avm_waitrequest) begin
                    ts_value_d = avm_readdata;
                    ts_ok_d    = (avm_readdata == EXPECTED_TS);
                    state_d    = FINISH;
                    avm_read_d = 1'b0;
                    done_d     = 1'b1;
                end else if (cnt_expired) begin
                    timeout_d  = 1'b1;
                    state_d    = FINISH;
                    avm_read_d = 1'b0;
                    done_d     = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                avm_read_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            auto_q        <= AUTO_START;
            avm_read_q    <= 1'b0;
            avm_address_q <= SYSID_ADDR_ID;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            timeout_q     <= 1'b0;
            id_value_q    <= '0;
            ts_value_q    <= '0;
        end else begin
            state_q       <= state_d;
            auto_q        <= auto_d;
            avm_read_q    <= avm_read_d;
            avm_address_q <= avm_address_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            id_ok_q       <= id_ok_d;
            ts_ok_q       <= ts_ok_d;
            timeout_q     <= timeout_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
        end
    end

    assign avm_address = avm_address_q;
    assign avm_read    = avm_read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_hwjsoc_sysid_checker.sv
// ---------------------------------------------------------------------------
// tb_hwjsoc_sysid_checker
// Scoreboard bench: each launched sequence pushes its expected result and
// the cycle its done pulse must appear; a monitor pops on every done pulse.
// A second monitor checks that read/address stay put while stalled.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hwjsoc_sysid_checker;

    localparam logic [31:0] GOOD_ID = 32'd16;
    localparam logic [31:0] GOOD_TS = 32'd1589565123;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Responder model
    logic [31:0] rsp_id;
    logic [31:0] rsp_ts;
    int          stall_id;
    int          stall_ts;
    int          rsp_cnt = 0;

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        to;
        logic [31:0] idv;
        logic [31:0] tsv;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    hwjsoc_sysid_checker #(
        .EXPECTED_ID    (GOOD_ID),
        .EXPECTED_TS    (GOOD_TS),
        .TIMEOUT_CYCLES (4),
        .AUTO_START     (1'b1)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout         (timeout),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    assign avm_readdata    = avm_address ? rsp_ts : rsp_id;
    assign avm_waitrequest = avm_read && (rsp_cnt < (avm_address ? stall_ts : stall_id));

    always @(posedge clock) begin
        if (avm_read && avm_waitrequest) rsp_cnt <= rsp_cnt + 1;
        else                             rsp_cnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h), required %0d (0x%08h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending sequence", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("id_ok",      id_ok, e.id_ok);
                chk("ts_ok",      ts_ok, e.ts_ok);
                chk("timeout",    timeout, e.to);
                chk("id_value",   id_value, e.idv);
                chk("ts_value",   ts_value, e.tsv);
                chk("busy_at_done", busy, 1);
                chk("read_at_done", avm_read, 0);
            end
        end
    end

    // Stall stability monitor
    logic prev_stall = 1'b0;
    logic prev_addr  = 1'b0;
    logic prev_rst   = 1'b0;
    always @(negedge clock) begin
        if (prev_stall && prev_rst && done !== 1'b1) begin
            chk("read_held", avm_read, 1);
            chk("addr_held", avm_address, prev_addr);
        end
        prev_stall <= avm_read && avm_waitrequest;
        prev_addr  <= avm_address;
        prev_rst   <= reset_n;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic issue_start(output int n);
        start = 1'b1;
        @(posedge clock);
        #1;
        n     = cyc;
        start = 1'b0;
    endtask

    task automatic push_exp(input logic iok, input logic tok, input logic to,
                            input logic [31:0] idv, input logic [31:0] tsv, input int c);
        exp_t e;
        e.id_ok = iok; e.ts_ok = tok; e.to = to; e.idv = idv; e.tsv = tsv; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_idle: busy=%0d pending=%0d after 60 cycles, required idle",
                     tag, busy, exp_q.size());
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_read"},    avm_read, 0);
        chk({tag, "_addr"},    avm_address, 0);
        chk({tag, "_busy"},    busy, 0);
        chk({tag, "_done"},    done, 0);
        chk({tag, "_id_ok"},   id_ok, 0);
        chk({tag, "_ts_ok"},   ts_ok, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_id_val"},  id_value, 0);
        chk({tag, "_ts_val"},  ts_value, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n  = 1'b0;
        start    = 1'b0;
        rsp_id   = GOOD_ID;
        rsp_ts   = GOOD_TS;
        stall_id = 0;
        stall_ts = 0;
        tick(3);
        check_zero("reset");

        // Auto start after reset release, zero-wait responder
        reset_n = 1'b1;
        tick(1);
        n = cyc;
        push_exp(1, 1, 0, GOOD_ID, GOOD_TS, n + 2);
        chk("auto_read_c1", avm_read, 1);
        chk("auto_addr_c1", avm_address, 0);
        chk("auto_busy_c1", busy, 1);
        tick(1);
        chk("auto_read_c2", avm_read, 1);
        chk("auto_addr_c2", avm_address, 1);
        wait_idle("auto");
        chk("idle_busy", busy, 0);
        chk("idle_ok_hold", id_ok, 1);

        // Wrong ID
        rsp_id = 32'd17;
        issue_start(n);
        chk("start_clears_id_ok", id_ok, 0);
        push_exp(0, 1, 0, 32'd17, GOOD_TS, n + 2);
        wait_idle("bad_id");

        // Three stall cycles on each read; start pulses mid-sequence ignored
        rsp_id   = GOOD_ID;
        stall_id = 3;
        stall_ts = 3;
        issue_start(n);
        push_exp(1, 1, 0, GOOD_ID, GOOD_TS, n + 8);
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle("stall3");

        // Data returned in the very cycle the stall count hits the limit
        stall_id = 4;
        stall_ts = 0;
        issue_start(n);
        push_exp(1, 1, 0, GOOD_ID, GOOD_TS, n + 6);
        wait_idle("edge_ok");

        // Timestamp read never completes
        stall_id = 0;
        stall_ts = 1000;
        rsp_ts   = 32'h1234_5678;
        issue_start(n);
        push_exp(1, 0, 1, GOOD_ID, GOOD_TS, n + 6);
        while (cyc < n + 7) tick(1);
        chk("ts_to_read_after", avm_read, 0);
        chk("ts_to_busy_after", busy, 0);
        chk("ts_to_flag_hold", timeout, 1);
        chk("ts_to_id_ok_hold", id_ok, 1);
        wait_idle("ts_timeout");

        // ID read never completes: sequence aborts before the timestamp read
        stall_id = 1000;
        rsp_id   = 32'd99;
        issue_start(n);
        push_exp(0, 0, 1, GOOD_ID, GOOD_TS, n + 5);
        wait_idle("id_timeout");

        // Start during RD_ID ignored, then reset during RD_TS: no done pulse
        rsp_id   = GOOD_ID;
        rsp_ts   = GOOD_TS;
        stall_id = 2;
        stall_ts = 1000;
        issue_start(n);
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        chk("pre_reset_in_ts", avm_address, 1);
        reset_n = 1'b0;
        tick(1);
        check_zero("midreset");
        tick(2);
        chk("midreset_hold_read", avm_read, 0);
        chk("midreset_hold_done", done, 0);

        // Release: auto start runs again
        stall_id = 0;
        stall_ts = 0;
        reset_n  = 1'b1;
        tick(1);
        n = cyc;
        push_exp(1, 1, 0, GOOD_ID, GOOD_TS, n + 2);
        wait_idle("auto2");

        tick(3);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
